// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory target: FSM states, bus event kinds, default address.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StDevAck,
        StWAddr,
        StWAck,
        StWData,
        StDAck,
        StRData,
        StRAck,
        StIgnore
    } i2c_state_e;

    typedef enum logic [2:0] {
        EvNone,
        EvStart,
        EvStop,
        EvRise,
        EvFall
    } bus_ev_e;

    localparam logic [6:0] DefDevAddr = 7'h50;

    // START/STOP win over clock edges seen in the same cycle.
    function automatic bus_ev_e classify(input logic start_det, input logic stop_det,
                                         input logic scl_rise, input logic scl_fall);
        if (start_det)     return EvStart;
        else if (stop_det) return EvStop;
        else if (scl_rise) return EvRise;
        else if (scl_fall) return EvFall;
        else               return EvNone;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA and derives one-cycle edge, START and STOP strobes.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic       scl_s;

    // Reset to the idle-bus level so release of reset does not look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C target with an internal byte memory, auto-incrementing word pointer and burst read/write.
module i2c_mem_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DefDevAddr,
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned PTR_W    = $clog2(DEPTH),
    parameter logic [7:0]  INIT_VAL = 8'h91
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             busy,
    output logic             wr_pulse,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             nack_addr
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    i2c_state_e       state_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [PTR_W-1:0] ptr_q;
    logic             rw_q;
    logic [7:0]       mem_q [DEPTH];

    bus_ev_e          ev;
    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr_inc, rx_ptr;

    assign ev      = classify(start_det, stop_det, scl_rise, scl_fall);
    assign rx_byte = {shift_q[6:0], sda_s};
    assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign rx_ptr  = PTR_W'({24'd0, rx_byte} % DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            nack_addr <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[PTR_W'(i)] <= INIT_VAL;
        end else begin
            wr_pulse  <= 1'b0;
            nack_addr <= 1'b0;
            if (ev == EvStart) begin
                state_q   <= StDevAddr;
                bit_cnt_q <= '0;
                sda_oe    <= 1'b0;
            end else if (ev == EvStop) begin
                state_q <= StIdle;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    StDevAddr, StWAddr, StWData: begin
                        if (ev == EvRise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                if (state_q == StDevAddr) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_q <= StDevAck;
                                        busy    <= 1'b1;
                                        rw_q    <= rx_byte[0];
                                    end else begin
                                        state_q   <= StIgnore;
                                        busy      <= 1'b0;
                                        nack_addr <= 1'b1;
                                    end
                                end else if (state_q == StWAddr) begin
                                    ptr_q   <= rx_ptr;
                                    state_q <= StWAck;
                                end else begin
                                    mem_q[ptr_q] <= rx_byte;
                                    wr_pulse     <= 1'b1;
                                    wr_addr      <= ptr_q;
                                    wr_data      <= rx_byte;
                                    ptr_q        <= ptr_inc;
                                    state_q      <= StDAck;
                                end
                            end
                        end
                    end
                    // First fall drives ACK, second fall releases it and moves on.
                    StDevAck, StWAck, StDAck: begin
                        if (ev == EvFall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                bit_cnt_q <= '0;
                                if (state_q == StDevAck && rw_q) begin
                                    shift_q <= mem_q[ptr_q];
                                    sda_oe  <= ~mem_q[ptr_q][7];
                                    state_q <= StRData;
                                end else if (state_q == StDevAck) begin
                                    state_q <= StWAddr;
                                end else begin
                                    state_q <= StWData;
                                end
                            end
                        end
                    end
                    StRData: begin
                        if (ev == EvRise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (ev == EvFall) begin
                            if (bit_cnt_q == 4'd0) begin
                                sda_oe <= ~shift_q[7];
                            end else if (bit_cnt_q == 4'd8) begin
                                sda_oe  <= 1'b0;
                                ptr_q   <= ptr_inc;
                                state_q <= StRAck;
                            end else begin
                                shift_q <= {shift_q[6:0], 1'b0};
                                sda_oe  <= ~shift_q[6];
                            end
                        end
                    end
                    StRAck: begin
                        if (ev == EvRise) begin
                            if (!sda_s) begin
                                shift_q   <= mem_q[ptr_q];
                                bit_cnt_q <= '0;
                                state_q   <= StRData;
                            end else begin
                                state_q <= StIgnore;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: bit-banged I2C master, scoreboard for memory writes and address NACKs.
module tb_i2c_mem_slave;
    import i2c_pkg::*;

    localparam int Q = 5;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_pulse, nack_addr;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    int   n_tests = 0;
    int   n_fail = 0;
    int   oe_seen = 0;
    logic watch_oe = 1'b0;
    wr_t  wr_q[$];
    bit   nack_q[$];
    wr_t  mon_e;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_mem_slave dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .nack_addr(nack_addr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT strobes an output.
    always @(negedge clk) begin
        if (!rst && wr_pulse) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr %0h data %0h, required no write",
                         wr_addr, wr_data);
            end else begin
                mon_e = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
        if (!rst && nack_addr) begin
            n_tests++;
            if (nack_q.size() == 0) begin
                n_fail++;
                $display("FAIL nack_unexpected: got nack_addr 1, required 0");
            end else begin
                void'(nack_q.pop_front());
            end
        end
        if (watch_oe && sda_oe) oe_seen++;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL timeout: got no finish, required finish within 60000 cycles");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        #1 r = sda_line;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic wr(input string name, input logic [7:0] b, input logic exp_ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, r);
        check(name, 32'(r), 32'(exp_ack));
    endtask

    task automatic rd(input string name, input logic nack, input logic [7:0] exp);
        logic       r;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(nack, r);
        check(name, 32'(d), 32'(exp));
    endtask

    // Read three bytes from word 0; used after power-up and after mid-transfer reset.
    task automatic read_zero_three(input string tag);
        bus_start();
        wr({tag, "_dev_w"}, 8'hA0, 1'b0);
        wr({tag, "_word"}, 8'h00, 1'b0);
        bus_start();
        wr({tag, "_dev_r"}, 8'hA1, 1'b0);
        rd({tag, "_rd0"}, 1'b0, 8'h91);
        rd({tag, "_rd1"}, 1'b0, 8'h91);
        rd({tag, "_rd2"}, 1'b1, 8'h91);
        check({tag, "_oe_after_nack"}, 32'(sda_oe), 0);
        bus_stop();
        check({tag, "_busy_after_stop"}, 32'(busy), 0);
    endtask

    initial begin
        logic r;
        wait_clk(3);
        #1;
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_pulse", 32'(wr_pulse), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_nack_addr", 32'(nack_addr), 0);
        @(negedge clk) rst = 1'b0;
        wait_clk(4);

        // 1: power-up contents
        read_zero_three("t1");

        // 2: burst write, then repeated-START read back
        bus_start();
        wr("t2_dev_w", 8'hA0, 1'b0);
        check("t2_busy", 32'(busy), 1);
        wr("t2_word", 8'h10, 1'b0);
        wr_q.push_back(wr_t'{addr: 7'h10, data: 8'hA5});
        wr("t2_d0", 8'hA5, 1'b0);
        wr_q.push_back(wr_t'{addr: 7'h11, data: 8'h3C});
        wr("t2_d1", 8'h3C, 1'b0);
        bus_start();
        wr("t2_dev_w2", 8'hA0, 1'b0);
        wr("t2_word2", 8'h10, 1'b0);
        bus_start();
        wr("t2_dev_r", 8'hA1, 1'b0);
        rd("t2_rd0", 1'b0, 8'hA5);
        rd("t2_rd1", 1'b1, 8'h3C);
        bus_stop();

        // 3: pointer wrap on write, then read with no word address
        bus_start();
        wr("t3_dev_w", 8'hA0, 1'b0);
        wr("t3_word", 8'h7F, 1'b0);
        wr_q.push_back(wr_t'{addr: 7'h7F, data: 8'h11});
        wr("t3_d0", 8'h11, 1'b0);
        wr_q.push_back(wr_t'{addr: 7'h00, data: 8'h22});
        wr("t3_d1", 8'h22, 1'b0);
        bus_stop();
        bus_start();
        wr("t3_dev_r", 8'hA1, 1'b0);
        rd("t3_rd_ptr01", 1'b1, 8'h91);
        bus_stop();
        bus_start();
        wr("t3_dev_w2", 8'hA0, 1'b0);
        wr("t3_word2", 8'h7F, 1'b0);
        bus_start();
        wr("t3_dev_r2", 8'hA1, 1'b0);
        rd("t3_rd7f", 1'b0, 8'h11);
        rd("t3_rd00", 1'b1, 8'h22);
        bus_stop();

        // 4: foreign device address
        watch_oe = 1'b1;
        nack_q.push_back(1'b1);
        bus_start();
        wr("t4_dev_nack", 8'hA2, 1'b1);
        check("t4_busy", 32'(busy), 0);
        wr("t4_data_nack", 8'h55, 1'b1);
        bus_stop();
        watch_oe = 1'b0;
        check("t4_oe_quiet", 32'(oe_seen), 0);

        // 5: STOP in the middle of a data byte
        bus_start();
        wr("t5_dev_w", 8'hA0, 1'b0);
        wr("t5_word", 8'h20, 1'b0);
        for (int i = 0; i < 4; i++) bus_bit(1'(i % 2 == 0), r);
        bus_stop();
        check("t5_busy", 32'(busy), 0);
        check("t5_state_idle", 32'(dut.state_q), 32'(StIdle));
        bus_start();
        wr("t5_dev_w2", 8'hA0, 1'b0);
        wr("t5_word2", 8'h20, 1'b0);
        bus_start();
        wr("t5_dev_r", 8'hA1, 1'b0);
        rd("t5_rd20", 1'b1, 8'h91);
        bus_stop();

        // 6: reset while the target is driving a '0' read bit (0xA5 bit 6)
        bus_start();
        wr("t6_dev_w", 8'hA0, 1'b0);
        wr("t6_word", 8'h10, 1'b0);
        bus_start();
        wr("t6_dev_r", 8'hA1, 1'b0);
        bus_bit(1'b1, r);
        check("t6_bit7", 32'(r), 1);
        check("t6_driving_zero", 32'(sda_oe), 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_oe_released", 32'(sda_oe), 0);
        check("t6_busy_cleared", 32'(busy), 0);
        @(negedge clk) rst = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4 * Q);
        read_zero_three("t6");

        wait_clk(20);
        check("wr_q_drained", 32'(wr_q.size()), 0);
        check("nack_q_drained", 32'(nack_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
